instr_fetch_port: RTL and testbench
===================================

// Module: instr_fetch_port
// PURPOSE
//  Instruction-memory side of the PCU fetch interface. Takes the 12-bit fetch address from the PCU.
//  Runs a req/ack read to program memory and returns the opcode byte on D_BUS.
//  Holds stall high while a read is outstanding; stall gates the PCU/pipeline clock enable.
//  Inserts NOP bubbles while waiting and on memory timeout.
// PARAMETERS
//  NOP_OPCODE  8'h00  byte driven on D_BUS whenever no valid instruction is presented
//  TIMEOUT     16     max REQ cycles before abandoning a read; 0 = never time out
// PORTS
//  clock      in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-low reset
//  address    in   12  fetch address from PCU; stable while stall=1
//  D_BUS      out  8   registered instruction byte to PCU/decoder
//  stall      out  1   1 = fetch outstanding, PCU must hold address
//  mem_req    out  1   read request to program memory
//  mem_addr   out  12  read address (= address while mem_req=1)
//  mem_ack    in   1   memory read done, mem_rdata valid this cycle
//  mem_rdata  in   8   memory read data
//  fetch_err  out  1   one-cycle pulse on timeout
//  err_count  out  8   saturating timeout counter
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, D_BUS=NOP_OPCODE, stall=0, mem_req=0, fetch_err=0.
//   Reset also clears err_count and the wait counter. Outputs drop without waiting for a clock.
//  FSM states: IDLE, REQ, ISSUE.
//   IDLE -> REQ unconditionally on the first edge after reset release.
//   REQ: stall=1, mem_req=1, mem_addr=address. wait_cnt increments each cycle.
//    mem_ack=1 -> D_BUS<=mem_rdata, -> ISSUE.
//    else if TIMEOUT!=0 and wait_cnt==TIMEOUT-1 -> D_BUS<=NOP_OPCODE, fetch_err<=1, err_count++ (sat 8'hFF), -> ISSUE.
//    ack and timeout in the same cycle -> ack wins, no error.
//   ISSUE: stall=0, mem_req=0. D_BUS holds the fetched byte for exactly this cycle.
//    The PCU advances on this edge. D_BUS<=NOP_OPCODE, wait_cnt<=0, -> REQ.
//  Latency: ack in cycle N -> D_BUS valid and stall=0 in cycle N+1.
//   Minimum fetch = 2 cycles (REQ with immediate ack, then ISSUE).
//  mem_ack and mem_rdata are ignored outside REQ. A spurious ack has no effect.
//  mem_req, mem_addr and stall are combinational from state. D_BUS, fetch_err and err_count are registered.
//  wait_cnt width = $clog2(TIMEOUT+1), min 1 bit. It never wraps inside REQ.
//  fetch_err is high only in the ISSUE cycle that follows a timeout.
//  Address 12'hFFF has no special handling; wrap is owned by the PCU.
// CONFIGURATION
//  LAST_HIT_EN defined: one-entry cache of {tag_valid, tag[11:0], data[7:0]}.
//   Filled on every acked read; a timeout does not fill it.
//   Entering REQ with tag_valid && address==tag: mem_req stays 0, D_BUS<=data, -> ISSUE next edge.
//   A hit costs 1 stall cycle and no memory traffic. Reset clears tag_valid.
//  LAST_HIT_EN undefined: no cache logic; every fetch goes to memory.
// TESTING
//  1 reset=0 mid-REQ -> mem_req,stall drop immediately; D_BUS=8'h00, err_count=0; after release IDLE -> REQ.
//  2 address=12'h005, ack after 2 wait cycles, rdata=8'hA3 -> mem_req high 3 cycles, mem_addr=12'h005;
//    next cycle D_BUS=8'hA3, stall=0; following cycle D_BUS=8'h00.
//  3 TIMEOUT=4, no ack -> 4 REQ cycles, then ISSUE with D_BUS=8'h00, fetch_err=1 for 1 cycle, err_count=1.
//  4 TIMEOUT=4, ack with rdata=8'h5C in the 4th REQ cycle -> D_BUS=8'h5C, fetch_err=0, err_count unchanged.
//  5 Spurious ack during ISSUE with rdata=8'hFF -> D_BUS unaffected; 300 timeouts -> err_count holds 8'hFF.
//  6 LAST_HIT_EN: fetch 12'h010 (rdata 8'h42) twice -> second fetch has mem_req=0, 1 stall cycle, D_BUS=8'h42.

Source files
------------

// File: rtl/instr_fetch_port.sv
// Instruction-memory side of the PCU fetch interface: req/ack read, opcode return, stall and NOP bubbles.
// Optional one-entry last-fetch cache enabled by defining LAST_HIT_EN.
module instr_fetch_port #(
  parameter logic [7:0]  NOP_OPCODE = 8'h00,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address,
  output logic [7:0]  D_BUS,
  output logic        stall,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        fetch_err,
  output logic [7:0]  err_count
);

  localparam int unsigned WCW_RAW = $clog2(TIMEOUT + 1);
  localparam int unsigned WCW     = (WCW_RAW < 1) ? 1 : WCW_RAW;
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [WCW-1:0] TO_LAST = TO_EN ? WCW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WCW-1:0]   r_wait_cnt;
  logic [7:0]       r_d_bus;
  logic             r_fetch_err;
  logic [7:0]       r_err_count;
  logic             w_in_req;
  logic             w_hit;
  logic [7:0]       w_hit_data;
  logic             w_ack;
  logic             w_timeout;

  assign w_in_req = (r_state == S_REQ);

`ifdef LAST_HIT_EN
  logic        r_tag_valid;
  logic [11:0] r_tag;
  logic [7:0]  r_data;

  assign w_hit      = w_in_req && r_tag_valid && (address == r_tag);
  assign w_hit_data = r_data;

  // Last-fetch cache: filled by every acked memory read, never by a timeout
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tag_valid <= 1'b0;
      r_tag       <= '0;
      r_data      <= '0;
    end else if (w_ack) begin
      r_tag_valid <= 1'b1;
      r_tag       <= address;
      r_data      <= mem_rdata;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = NOP_OPCODE;
`endif

  // A cache hit suppresses the memory request, so any ack seen then is ignored
  assign w_ack     = w_in_req && !w_hit && mem_ack;
  assign w_timeout = TO_EN && w_in_req && !w_hit && !mem_ack && (r_wait_cnt == TO_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_REQ;
      S_REQ:   if (w_hit || w_ack || w_timeout) w_next = S_ISSUE;
      S_ISSUE: w_next = S_REQ;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    mem_req  = 1'b0;
    mem_addr = address;
    case (r_state)
      S_REQ: begin
        stall   = 1'b1;
        mem_req = !w_hit;
      end
      default: ;
    endcase
  end

  // Registered data path: instruction byte, error pulse, saturating error count, wait counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_d_bus     <= NOP_OPCODE;
      r_fetch_err <= 1'b0;
      r_err_count <= 8'h00;
      r_wait_cnt  <= '0;
    end else begin
      r_fetch_err <= 1'b0;
      case (r_state)
        S_REQ: begin
          if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + WCW'(1);
          if (w_hit) begin
            r_d_bus <= w_hit_data;
          end else if (w_ack) begin
            r_d_bus <= mem_rdata;
          end else if (w_timeout) begin
            r_d_bus     <= NOP_OPCODE;
            r_fetch_err <= 1'b1;
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
          end
        end
        S_ISSUE: begin
          r_d_bus    <= NOP_OPCODE;
          r_wait_cnt <= '0;
        end
        default: r_wait_cnt <= '0;
      endcase
    end
  end

  assign D_BUS     = r_d_bus;
  assign fetch_err = r_fetch_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_fetch_port.sv
// Self-checking bench for instr_fetch_port: directed steps plus randomized fetches
// checked against a transaction-level model of the fetch rules.
module tb_instr_fetch_port;

  localparam int unsigned TO  = 4;
  localparam logic [7:0]  NOP = 8'h00;

  logic        clock;
  logic        reset;
  logic [11:0] address;
  logic [7:0]  D_BUS;
  logic        stall;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        fetch_err;
  logic [7:0]  err_count;

  int n_checks;
  int n_fail;

  // Behavioural model state
  int          m_errcnt;
  bit          m_cvalid;
  logic [11:0] m_ctag;
  logic [7:0]  m_cdata;

  instr_fetch_port #(.NOP_OPCODE(NOP), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .address   (address),
    .D_BUS     (D_BUS),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .fetch_err (fetch_err),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One complete fetch, entered in the first REQ cycle. ack_dly >= TO means memory never answers.
  task automatic fetch(input logic [11:0] a, input int ack_dly, input logic [7:0] rd);
    bit         hit;
    bit         acked;
    int         n_req;
    logic [7:0] exp_d;
    bit         exp_err;
    hit = 1'b0;
`ifdef LAST_HIT_EN
    hit = m_cvalid && (m_ctag == a);
`endif
    acked = !hit && (ack_dly < int'(TO));
    if (hit) begin
      n_req = 1; exp_d = m_cdata; exp_err = 1'b0;
    end else if (acked) begin
      n_req = ack_dly + 1; exp_d = rd; exp_err = 1'b0;
      m_cvalid = 1'b1; m_ctag = a; m_cdata = rd;
    end else begin
      n_req = int'(TO); exp_d = NOP; exp_err = 1'b1;
      if (m_errcnt < 255) m_errcnt++;
    end
    address = a;
    for (int k = 0; k < n_req; k++) begin
      mem_ack   = acked && (k == ack_dly);
      mem_rdata = (acked && k == ack_dly) ? rd : 8'($urandom);
      check("req_stall", 32'(stall), 32'(1));
      check("req_mem_req", 32'(mem_req), 32'(!hit));
      if (!hit) check("req_mem_addr", 32'(mem_addr), 32'(a));
      check("req_dbus_nop", 32'(D_BUS), 32'(NOP));
      check("req_fetch_err", 32'(fetch_err), 32'(0));
      step();
    end
    // ISSUE cycle, with a spurious ack that must be ignored
    mem_ack   = 1'b1;
    mem_rdata = 8'hFF;
    check("issue_stall", 32'(stall), 32'(0));
    check("issue_mem_req", 32'(mem_req), 32'(0));
    check("issue_dbus", 32'(D_BUS), 32'(exp_d));
    check("issue_fetch_err", 32'(fetch_err), 32'(exp_err));
    check("issue_err_count", 32'(err_count), 32'(m_errcnt));
    step();
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
  endtask

  initial begin
    logic [11:0] ra;
    n_checks = 0;
    n_fail   = 0;
    m_errcnt = 0;
    m_cvalid = 1'b0;
    m_ctag   = '0;
    m_cdata  = '0;
    reset     = 1'b0;
    address   = 12'h000;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;

    // Reset state
    #2;
    check("rst_dbus", 32'(D_BUS), 32'(NOP));
    check("rst_stall", 32'(stall), 32'(0));
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_fetch_err", 32'(fetch_err), 32'(0));
    check("rst_err_count", 32'(err_count), 32'(0));
    step(); step();
    reset = 1'b1;
    step();

    // Basic read with two wait cycles
    fetch(12'h005, 2, 8'hA3);
    // Ack in the last allowed REQ cycle beats the timeout
    fetch(12'h007, 3, 8'h5C);
    // No ack: timeout
    fetch(12'h008, 99, 8'h00);
    // Repeat fetch of the same address (cache hit when enabled)
    fetch(12'h010, 0, 8'h42);
    fetch(12'h010, 1, 8'h42);
    // Saturation of the error counter
    for (int i = 0; i < 300; i++) fetch(12'h3FF, 99, 8'h00);
    check("sat_err_count", 32'(err_count), 32'(8'hFF));

    // Asynchronous reset in the middle of a REQ
    address   = 12'h123;
    mem_ack   = 1'b0;
    step();
    check("midreq_mem_req", 32'(mem_req), 32'(1));
    reset = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'(0));
    check("midrst_stall", 32'(stall), 32'(0));
    check("midrst_dbus", 32'(D_BUS), 32'(NOP));
    check("midrst_err_count", 32'(err_count), 32'(0));
    m_errcnt = 0;
    m_cvalid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("idle_stall", 32'(stall), 32'(0));
    step();
    fetch(12'h123, 1, 8'h9D);

    // Randomized fetches over a small address pool so repeats occur
    for (int i = 0; i < 200; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 5));
      fetch(ra, int'($urandom_range(0, 5)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
